// File: rtl/dbc_psc_event_scheduler.sv
// dbc_psc_event_scheduler: latches DbC port change pulses into RW1C bits and posts one
// coalesced Port Status Change Event per change episode over valid/ready.
module dbc_psc_event_scheduler #(
  parameter int HOLDOFF = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       DCE,
  input  logic       csc_set,
  input  logic       prc_set,
  input  logic       plc_set,
  input  logic       cec_set,
  input  logic       rw1c_wr,
  input  logic [3:0] rw1c_data,
  output logic       CSC,
  output logic       PRC,
  output logic       PLC,
  output logic       CEC,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [3:0] evt_status,
  output logic [7:0] evt_cnt,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, HOLD, POST, WAIT_CLR} state_t;
  state_t     r_state, w_state_nxt;
  logic [3:0] r_bits, w_bits_nxt;
  logic [3:0] r_hold, w_hold_nxt;
  logic [3:0] r_status, w_status_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  always_comb begin
    w_bits_nxt   = DCE ? ({cec_set, plc_set, prc_set, csc_set} | (r_bits & ~(rw1c_wr ? rw1c_data : 4'b0))) : 4'b0;
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_status_nxt = r_status;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      IDLE: if (|r_bits) begin
        w_state_nxt = HOLD;
        w_hold_nxt  = 4'(HOLDOFF - 1);
      end
      HOLD: if (r_bits == 4'b0) w_state_nxt = IDLE;
        else if (r_hold == 4'b0) begin
          w_state_nxt  = POST;
          w_status_nxt = r_bits;
        end else w_hold_nxt = r_hold - 4'd1;
      POST: if (evt_ready) begin
        w_state_nxt = WAIT_CLR;
        w_cnt_nxt   = r_cnt + 8'd1;
      end
      WAIT_CLR: if (r_bits == 4'b0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // disabling drops any pending or in-flight event without counting it
    if (!DCE) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = r_cnt;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_bits   <= 4'b0;
      r_hold   <= 4'b0;
      r_status <= 4'b0;
      r_cnt    <= 8'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bits   <= w_bits_nxt;
      r_hold   <= w_hold_nxt;
      r_status <= w_status_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end
  assign {CEC, PLC, PRC, CSC} = r_bits;
  assign evt_valid  = (r_state == POST);
  assign evt_status = r_status;
  assign evt_cnt    = r_cnt;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_dbc_psc_event_scheduler.sv
// tb_dbc_psc_event_scheduler: directed scenario tests for the PSC event scheduler.
module tb_dbc_psc_event_scheduler;
  logic       clock = 1'b0;
  logic       reset_n, DCE, csc_set, prc_set, plc_set, cec_set, rw1c_wr, evt_ready;
  logic [3:0] rw1c_data;
  logic       CSC, PRC, PLC, CEC, evt_valid, busy;
  logic [3:0] evt_status;
  logic [7:0] evt_cnt;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  dbc_psc_event_scheduler #(.HOLDOFF(4)) dut (
    .clock(clock), .reset_n(reset_n), .DCE(DCE),
    .csc_set(csc_set), .prc_set(prc_set), .plc_set(plc_set), .cec_set(cec_set),
    .rw1c_wr(rw1c_wr), .rw1c_data(rw1c_data),
    .CSC(CSC), .PRC(PRC), .PLC(PLC), .CEC(CEC),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_status(evt_status),
    .evt_cnt(evt_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    {cec_set, plc_set, prc_set, csc_set} = m;
    tick();
    {cec_set, plc_set, prc_set, csc_set} = 4'b0;
  endtask

  task automatic clr(input logic [3:0] m);
    rw1c_wr = 1'b1;
    rw1c_data = m;
    tick();
    rw1c_wr = 1'b0;
    rw1c_data = 4'b0;
  endtask

  task automatic accept();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; DCE = 1'b1; evt_ready = 1'b0; rw1c_wr = 1'b0; rw1c_data = 4'b0;
    {cec_set, plc_set, prc_set, csc_set} = 4'b0;
    #3;
    checks++;
    if ({CEC, PLC, PRC, CSC, evt_valid, busy} !== 6'b0 || evt_status !== 4'b0 || evt_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: bits=%b valid=%b busy=%b status=%b cnt=%0d, want all 0",
               {CEC, PLC, PRC, CSC}, evt_valid, busy, evt_status, evt_cnt);
    end
    tick(); tick();
    reset_n = 1'b1;
    evt_ready = 1'b1;
    repeat (3) tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: cnt=%0d busy=%b, want 0 0", evt_cnt, busy);
    end
  endtask

  task automatic test_enable_latency();
    pulse(4'b0001);
    checks++;
    if (CSC !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL latch: CSC=%b busy=%b, want 1 0", CSC, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_entry: busy=%b valid=%b, want 1 0", busy, evt_valid);
    end
    repeat (3) tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: valid=%b after E4, want 0", evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_status !== 4'b0001) begin
      errors++;
      $display("FAIL post: valid=%b status=%b, want 1 0001", evt_valid, evt_status);
    end
    accept();
    checks++;
    if (evt_valid !== 1'b0 || evt_cnt !== exp_cnt || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: valid=%b cnt=%0d busy=%b, want 0 %0d 1", evt_valid, evt_cnt, busy, exp_cnt);
    end
    clr(4'b0001);
    checks++;
    if (CSC !== 1'b0) begin
      errors++;
      $display("FAIL rw1c: CSC=%b, want 0", CSC);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_clr_exit: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_coalesce();
    pulse(4'b0001);
    tick();
    pulse(4'b0010);
    tick(); tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL coalesce_early: valid=%b after E4, want 0", evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_status !== 4'b0011) begin
      errors++;
      $display("FAIL coalesce: valid=%b status=%b, want 1 0011", evt_valid, evt_status);
    end
    accept();
    checks++;
    if (evt_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL coalesce_cnt: cnt=%0d, want %0d", evt_cnt, exp_cnt);
    end
    clr(4'b0011);
    tick();
  endtask

  task automatic test_backpressure();
    pulse(4'b0001);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) pulse(4'b0100); else tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_status !== 4'b0001) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b status=%b, want 1 0001", i, evt_valid, evt_status);
      end
    end
    checks++;
    if (PLC !== 1'b1 || CSC !== 1'b1) begin
      errors++;
      $display("FAIL stall_latch: PLC=%b CSC=%b, want 1 1", PLC, CSC);
    end
    accept();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_clr[%0d]: valid=%b busy=%b, want 0 1", i, evt_valid, busy);
      end
    end
    checks++;
    if (evt_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL bp_cnt: cnt=%0d, want %0d", evt_cnt, exp_cnt);
    end
    clr(4'b0101);
    tick();
    checks++;
    if (busy !== 1'b0 || {CEC, PLC, PRC, CSC} !== 4'b0) begin
      errors++;
      $display("FAIL bp_exit: busy=%b bits=%b, want 0 0000", busy, {CEC, PLC, PRC, CSC});
    end
  endtask

  task automatic test_clear_holdoff();
    pulse(4'b0001);
    tick();
    clr(4'b0001);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_abort: busy=%b, want 0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL holdoff_noevt[%0d]: valid=%b, want 0", i, evt_valid);
      end
    end
    checks++;
    if (evt_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL holdoff_cnt: cnt=%0d, want %0d", evt_cnt, exp_cnt);
    end
  endtask

  task automatic test_collision_dce();
    rw1c_wr = 1'b1;
    rw1c_data = 4'b1000;
    pulse(4'b1000);
    rw1c_wr = 1'b0;
    rw1c_data = 4'b0;
    checks++;
    if (CEC !== 1'b1) begin
      errors++;
      $display("FAIL collision: CEC=%b, want 1", CEC);
    end
    repeat (5) tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_status !== 4'b1000) begin
      errors++;
      $display("FAIL cec_post: valid=%b status=%b, want 1 1000", evt_valid, evt_status);
    end
    DCE = 1'b0;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b0 || {CEC, PLC, PRC, CSC} !== 4'b0 || evt_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL dce_drop: valid=%b busy=%b bits=%b cnt=%0d, want 0 0 0000 %0d",
               evt_valid, busy, {CEC, PLC, PRC, CSC}, evt_cnt, exp_cnt);
    end
    pulse(4'b0001);
    checks++;
    if (CSC !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dce_ignore: CSC=%b busy=%b, want 0 0", CSC, busy);
    end
    DCE = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] start;
    bit ok;
    start = exp_cnt;
    for (int e = 0; e < 256; e++) begin
      pulse(4'b0001);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        tick();
        ok = evt_valid;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL wrap_timeout[%0d]: valid=%b, want 1 within 20 cycles", e, evt_valid);
      end
      accept();
      clr(4'b0001);
      tick();
    end
    checks++;
    if (evt_cnt !== start || exp_cnt !== start) begin
      errors++;
      $display("FAIL wrap: cnt=%0d, want %0d", evt_cnt, start);
    end
  endtask

  initial begin
    test_reset();
    test_enable_latency();
    test_coalesce();
    test_backpressure();
    test_clear_holdoff();
    test_collision_dce();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
